// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: requester handshakes and decoder-side bus of the two-port memory arbiter.
interface mem_bus_arbiter_if;
  logic req0, we0, gnt0, done0;
  logic req1, we1, gnt1, done1;
  logic busy, busWriteEnable;
  logic [7:0] addr0, wdata0, addr1, wdata1;
  logic [7:0] rdata, busAddress, busWriteData, busReadData;
  modport master (
    output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, busReadData,
    input gnt0, done0, gnt1, done1, rdata, busAddress, busWriteEnable, busWriteData, busy
  );
  modport slave (
    input req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, busReadData,
    output gnt0, done0, gnt1, done1, rdata, busAddress, busWriteEnable, busWriteData, busy
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin two-port arbiter running fixed-length registered accesses on the decoder bus.
module mem_bus_arbiter #(
  parameter int WAIT_CYCLES = 2
) (
  input logic clk,
  input logic rst_n,
  mem_bus_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} stateT;
  stateT state, nState;
  logic owner, nOwner, lastGrant, nLastGrant, lWe, nWe;
  logic [3:0] cnt, nCnt;
  logic [7:0] lAddr, nAddr, lWdata, nWdata, nRdata, nBusAddress, nBusWriteData;
  logic nGnt0, nGnt1, nDone0, nDone1, nBusy, nBusWriteEnable;
  logic elig0, elig1, grant, win;
  always_comb begin
    // the requester completing in DONE is excluded so the other side gets a back-to-back turn
    elig0 = bus.req0 && !(state == DONE && !owner);
    elig1 = bus.req1 && !(state == DONE && owner);
    grant = state != ACCESS && (elig0 || elig1);
    win = (elig0 && elig1) ? !lastGrant : elig1;
    nState = state;
    nOwner = owner;
    nLastGrant = lastGrant;
    nCnt = cnt;
    nWe = lWe;
    nAddr = lAddr;
    nWdata = lWdata;
    nRdata = bus.rdata;
    nGnt0 = 1'b0;
    nGnt1 = 1'b0;
    nDone0 = 1'b0;
    nDone1 = 1'b0;
    nBusy = 1'b0;
    nBusAddress = 8'h00;
    nBusWriteEnable = 1'b0;
    nBusWriteData = 8'h00;
    if (grant) begin
      nState = ACCESS;
      nOwner = win;
      nLastGrant = win;
      nCnt = 4'(WAIT_CYCLES - 1);
      nWe = win ? bus.we1 : bus.we0;
      nAddr = win ? bus.addr1 : bus.addr0;
      nWdata = win ? bus.wdata1 : bus.wdata0;
      nGnt0 = !win;
      nGnt1 = win;
      nBusy = 1'b1;
      nBusAddress = nAddr;
      nBusWriteEnable = nWe;
      nBusWriteData = nWdata;
    end else if (state == ACCESS) begin
      if (cnt == 4'd0) begin
        nState = DONE;
        nRdata = lWe ? bus.rdata : bus.busReadData;
        nDone0 = !owner;
        nDone1 = owner;
      end else begin
        nCnt = cnt - 4'd1;
        nGnt0 = !owner;
        nGnt1 = owner;
        nBusy = 1'b1;
        nBusAddress = lAddr;
        nBusWriteData = lWdata;
      end
    end else begin
      nState = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      owner <= 1'b0;
      lastGrant <= 1'b1;
      cnt <= 4'd0;
      lWe <= 1'b0;
      lAddr <= 8'h00;
      lWdata <= 8'h00;
      bus.rdata <= 8'h00;
      bus.gnt0 <= 1'b0;
      bus.gnt1 <= 1'b0;
      bus.done0 <= 1'b0;
      bus.done1 <= 1'b0;
      bus.busy <= 1'b0;
      bus.busAddress <= 8'h00;
      bus.busWriteEnable <= 1'b0;
      bus.busWriteData <= 8'h00;
    end else begin
      state <= nState;
      owner <= nOwner;
      lastGrant <= nLastGrant;
      cnt <= nCnt;
      lWe <= nWe;
      lAddr <= nAddr;
      lWdata <= nWdata;
      bus.rdata <= nRdata;
      bus.gnt0 <= nGnt0;
      bus.gnt1 <= nGnt1;
      bus.done0 <= nDone0;
      bus.done1 <= nDone1;
      bus.busy <= nBusy;
      bus.busAddress <= nBusAddress;
      bus.busWriteEnable <= nBusWriteEnable;
      bus.busWriteData <= nBusWriteData;
    end
  end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed and randomized checks of mem_bus_arbiter against a transaction-level model
// of grant order, access timing and memory contents.
module tb_mem_bus_arbiter;
  localparam int W = 2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  mem_bus_arbiter_if ifA ();
  mem_bus_arbiter_if ifB ();
  mem_bus_arbiter #(.WAIT_CYCLES(W)) dutA (.clk(clk), .rst_n(rst_n), .bus(ifA));
  mem_bus_arbiter #(.WAIT_CYCLES(1)) dutB (.clk(clk), .rst_n(rst_n), .bus(ifB));
  logic [7:0] mem [256];
  logic [7:0] refMem [256];
  logic bdEn = 1'b0;
  logic [7:0] bdAddr = 8'h00, bdData = 8'h00;
  logic mLast;
  logic [7:0] mRdata;
  int compared = 0, mismatched = 0;
  // synchronous RAM behind the decoder, with a backdoor port for preloading
  always @(posedge clk) begin
    if (bdEn) mem[bdAddr] <= bdData;
    else if (ifA.busWriteEnable) mem[ifA.busAddress] <= ifA.busWriteData;
    ifA.busReadData <= mem[ifA.busAddress];
  end
  assign ifB.busReadData = (ifB.busAddress == 8'hFF) ? 8'h01 : 8'h00;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic idleCheck(input string tag);
    chk(tag, 32'({ifA.gnt1, ifA.gnt0, ifA.done1, ifA.done0, ifA.busy, ifA.busWriteEnable,
                  ifA.busAddress, ifA.busWriteData}), 32'(0));
  endtask
  // called at the negedge after the grant edge; returns at the negedge showing the done strobe
  task automatic access(input bit o);
    logic we;
    logic [7:0] a, wd, expRd;
    we = o ? ifA.we1 : ifA.we0;
    a = o ? ifA.addr1 : ifA.addr0;
    wd = o ? ifA.wdata1 : ifA.wdata0;
    expRd = we ? mRdata : refMem[a];
    for (int i = 0; i < W; i++) begin
      chk("accessCtl", 32'({ifA.gnt1, ifA.gnt0, ifA.done1, ifA.done0, ifA.busy, ifA.busWriteEnable}),
          32'({o, !o, 2'b00, 1'b1, we && i == 0}));
      chk("accessBus", 32'({ifA.busAddress, ifA.busWriteData}), 32'({a, wd}));
      @(negedge clk);
    end
    chk("doneCtl", 32'({ifA.gnt1, ifA.gnt0, ifA.done1, ifA.done0, ifA.busy, ifA.busWriteEnable}),
        32'({2'b00, o, !o, 2'b00}));
    chk("doneData", 32'({ifA.rdata, ifA.busAddress, ifA.busWriteData}), 32'({expRd, 16'h0000}));
    mLast = o;
    if (we) refMem[a] = wd;
    else mRdata = expRd;
  endtask
  initial begin
    logic [1:0] r;
    bit first;
    {ifA.req0, ifA.we0, ifA.addr0, ifA.wdata0, ifA.req1, ifA.we1, ifA.addr1, ifA.wdata1} = '0;
    {ifB.req0, ifB.we0, ifB.addr0, ifB.wdata0, ifB.req1, ifB.we1, ifB.addr1, ifB.wdata1} = '0;
    mLast = 1'b1;
    mRdata = 8'h00;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      bdEn = 1'b1;
      bdAddr = 8'(i);
      bdData = (i == 16) ? 8'hA5 : 8'($urandom);
      refMem[i] = bdData;
    end
    @(negedge clk);
    bdEn = 1'b0;
    idleCheck("resetBusA");
    chk("resetRdataA", 32'(ifA.rdata), 32'(0));
    chk("resetB", 32'({ifB.gnt0, ifB.gnt1, ifB.done0, ifB.done1, ifB.busy, ifB.rdata, ifB.busAddress}), 32'(0));
    rst_n = 1'b1;
    ifA.req0 = 1'b1;
    ifA.addr0 = 8'h10;
    @(negedge clk);
    access(1'b0);
    ifA.req0 = 1'b0;
    @(negedge clk);
    idleCheck("afterRead");
    ifA.req1 = 1'b1;
    ifA.we1 = 1'b1;
    ifA.addr1 = 8'hFB;
    ifA.wdata1 = 8'h3C;
    @(negedge clk);
    access(1'b1);
    ifA.req1 = 1'b0;
    @(negedge clk);
    idleCheck("afterWrite");
    chk("ledPort", 32'(mem[8'hFB]), 32'h3C);
    ifA.addr0 = 8'($urandom);
    ifA.req0 = 1'b1;
    @(negedge clk);
    ifA.req0 = 1'b0;
    access(1'b0);
    @(negedge clk);
    idleCheck("afterDrop");
    rst_n = 1'b0;
    ifA.req0 = 1'b1;
    ifA.req1 = 1'b1;
    ifA.we1 = 1'b0;
    ifA.addr0 = 8'h10;
    ifA.addr1 = 8'($urandom);
    @(negedge clk);
    mLast = 1'b1;
    mRdata = 8'h00;
    chk("resetRdataClear", 32'(ifA.rdata), 32'(0));
    rst_n = 1'b1;
    @(negedge clk);
    access(1'b0);
    @(negedge clk);
    access(1'b1);
    @(negedge clk);
    access(1'b0);
    @(negedge clk);
    access(1'b1);
    ifA.req0 = 1'b0;
    ifA.req1 = 1'b0;
    @(negedge clk);
    idleCheck("afterAlternate");
    for (int n = 0; n < 40; n++) begin
      r = 2'($urandom_range(1, 3));
      ifA.we0 = 1'($urandom);
      ifA.addr0 = 8'($urandom);
      ifA.wdata0 = 8'($urandom);
      ifA.we1 = 1'($urandom);
      ifA.addr1 = 8'($urandom);
      ifA.wdata1 = 8'($urandom);
      ifA.req0 = r[0];
      ifA.req1 = r[1];
      first = (r == 2'b11) ? !mLast : r[1];
      @(negedge clk);
      access(first);
      if (first) ifA.req1 = 1'b0;
      else ifA.req0 = 1'b0;
      if (r == 2'b11) begin
        @(negedge clk);
        access(!first);
        ifA.req0 = 1'b0;
        ifA.req1 = 1'b0;
      end
      @(negedge clk);
      idleCheck("randomIdle");
    end
    ifA.we0 = 1'b1;
    ifA.addr0 = 8'h30;
    ifA.wdata0 = 8'h77;
    ifA.req0 = 1'b1;
    @(negedge clk);
    chk("midResetAccess", 32'({ifA.gnt0, ifA.busWriteEnable, ifA.busAddress}), 32'({2'b11, 8'h30}));
    rst_n = 1'b0;
    ifA.req0 = 1'b0;
    @(negedge clk);
    idleCheck("midResetBus");
    chk("midResetRdata", 32'(ifA.rdata), 32'(0));
    refMem[8'h30] = 8'h77;
    mLast = 1'b1;
    mRdata = 8'h00;
    ifA.we0 = 1'b0;
    ifA.we1 = 1'b0;
    ifA.addr0 = 8'($urandom);
    ifA.addr1 = 8'($urandom);
    ifA.req0 = 1'b1;
    ifA.req1 = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    access(1'b0);
    ifA.req0 = 1'b0;
    @(negedge clk);
    access(1'b1);
    ifA.req1 = 1'b0;
    @(negedge clk);
    idleCheck("afterResetTie");
    ifB.req0 = 1'b1;
    ifB.addr0 = 8'hFF;
    @(negedge clk);
    chk("w1Access", 32'({ifB.gnt0, ifB.busy, ifB.done0, ifB.busAddress}), 32'({3'b110, 8'hFF}));
    @(negedge clk);
    chk("w1Done", 32'({ifB.gnt0, ifB.busy, ifB.done0, ifB.rdata}), 32'({3'b001, 8'h01}));
    ifB.req0 = 1'b0;
    @(negedge clk);
    chk("w1Idle", 32'({ifB.gnt0, ifB.busy, ifB.done0, ifB.busAddress}), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-port arbiter and access sequencer for the shared 8-bit address/data bus that feeds the memory/IO address decoder (RAM, UART buffers, LED port). It lets the CPU (requester 0) and the UART boot loader/DMA engine (requester 1) share the bus. Each access is a registered, fixed-length transaction. Priority is round-robin, and completion is signalled with a one-cycle `done` strobe.

## Interface
- `WAIT_CYCLES`, default 2: bus cycles per access, legal range 1..15. Read data is sampled at the end of the last cycle; 2 suits the synchronous RAM.
- `clk` in 1: system clock; all logic is rising-edge.
- `rst_n` in 1: synchronous, active-low reset.
- `req0` in 1: requester 0 (CPU) access request; held high until `done0`.
- `we0` in 1: requester 0 write (1) / read (0).
- `addr0` in 8: requester 0 address.
- `wdata0` in 8: requester 0 write data.
- `gnt0` out 1: requester 0 owns the bus.
- `done0` out 1: one-cycle completion strobe for requester 0.
- `req1`, `we1`, `addr1`, `wdata1`, `gnt1`, `done1`: same set for requester 1 (loader/DMA).
- `rdata` out 8: read data of the last completed read; valid while `doneN` is high.
- `busAddress` out 8: address to the decoder.
- `busWriteEnable` out 1: write strobe to the decoder.
- `busWriteData` out 8: write data to the bus.
- `busReadData` in 8: muxed read data returned by the decoder.
- `busy` out 1: high in ACCESS state.

## Operation
- **States:** IDLE, ACCESS, DONE.
- **Arbitration** (IDLE and DONE):
  - If only one request is eligible, it wins.
  - If both are eligible, the requester not equal to `lastGrant` wins.
- **Grant:**
  - Latch the winner's `we`/`addr`/`wdata` into internal registers.
  - Set `lastGrant`, load `cnt = WAIT_CYCLES-1`, and go to ACCESS.
  - Requester inputs are ignored from then until the next arbitration.
- **ACCESS:**
  - `gntN` is high for the owner.
  - `busAddress` and `busWriteData` drive the latched values.
  - `busWriteEnable` equals the latched `we` only in the first ACCESS cycle, so there is exactly one write strobe per access.
  - `cnt` decrements each cycle. When `cnt == 0`, capture `busReadData` into `rdata` (reads only; writes leave `rdata` unchanged) and go to DONE.
- **DONE:**
  - `doneN` is high for the owner; `gnt` is low; the bus is idle.
  - Arbitrate with the completing requester excluded. If the other requester is high, grant it (back-to-back to ACCESS); otherwise go to IDLE.
- **Completing requester:** must drop `req` by the cycle after `done`. A `req` still high in a later IDLE is a new request.
- **Aborts:** dropping `req` mid-ACCESS does not abort. The access completes and `done` still pulses.
- **Idle bus:** `busAddress = 0x00`, `busWriteEnable = 0`, `busWriteData = 0x00`.
- **Width:** `cnt` is 4 bits and never wraps; it is reloaded on every grant.

## Timing
- **Reset** (`rst_n` low at an edge):
  - State IDLE; `lastGrant = 1`, so requester 0 wins the first tie.
  - `cnt = 0`; `gnt0/1 = 0`, `done0/1 = 0`, `busy = 0`.
  - `rdata = 0x00`, `busAddress = 0x00`, `busWriteEnable = 0`, `busWriteData = 0x00`.
- **Reset mid-ACCESS:** the access is abandoned immediately, no `done` is issued, and the bus is idle in the next cycle.
- **Latency:**
  - `req` high in IDLE at cycle T gives ACCESS for cycles T+1..T+WAIT_CYCLES.
  - `done` and `rdata` are valid at T+WAIT_CYCLES+1.
- **Throughput:** one access per WAIT_CYCLES+1 cycles under continuous alternating demand.
- **Outputs:** all registered; no combinational path from `req`/`addr` to bus outputs.
- **Simultaneous events:** both `req` rising in the same IDLE cycle resolve by `lastGrant` only. A new `req` arriving during ACCESS waits for DONE.

## Test plan
- **Single read (WAIT_CYCLES=2):** after reset, `req0=1`, `we0=0`, `addr0=0x10`, memory[0x10]=0xA5. Expect:
  - `gnt0` and `busAddress=0x10` for 2 cycles, `busWriteEnable=0`.
  - `done0` one cycle later with `rdata=0xA5`.
- **Single write:** `req1=1`, `we1=1`, `addr1=0xFB`, `wdata1=0x3C`. Expect:
  - `busWriteEnable` high for exactly 1 cycle with `busAddress=0xFB`, `busWriteData=0x3C`.
  - LED port reads 0x3C; `done1` pulses; `rdata` unchanged.
- **Tie and alternation:** `req0` and `req1` both held from reset. Expect grants 0,1,0,1 back-to-back, with DONE of one directly followed by ACCESS of the other.
- **Mid-access drop:** `req0` drops in the 1st ACCESS cycle. Expect the access to complete, `done0` to pulse, and then IDLE.
- **Reset mid-access:** `rst_n=0` during ACCESS of a write. Expect:
  - All outputs at reset values next cycle, no `done`.
  - The next tie is won by requester 0.
- **WAIT_CYCLES=1:** read `addr0=0xFF` (UART status = 0x01). Expect one ACCESS cycle, then `done0` with `rdata=0x01`, 2 cycles after `req`.
